frame_vector_accumulator: RTL and testbench

- Sits directly downstream of the filter/reduce stage. Consumes its per-cycle N-lane vectors (histogram bin counts or passthrough data) plus chainId/bof/eof.
- For chains configured in accumulate mode, sums every vector of a frame (bof..eof) element-wise and emits a single accumulated vector at eof.
- Other chains pass through with matched latency.
- Runtime-reconfigurable over the shared configId/configData byte bus when tracing is low.

---
 rtl/frame_vector_accumulator.sv | 131 +++++++++++++
 tb/tb_frame_vector_accumulator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_vector_accumulator.sv
// Per-chain frame accumulator: sums every vector from bof to eof lane-wise with
// saturation and emits one result at eof; other chains pass through, 1-cycle latency.
module frame_vector_accumulator #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 1,
    parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_ACC_EN = '0,
    localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tracing,
    input  logic                  valid_in,
    input  logic                  eof_in,
    input  logic                  bof_in,
    input  logic [CW-1:0]         chainId_in,
    input  logic [7:0]            configId,
    input  logic [7:0]            configData,
    input  logic [DATA_WIDTH-1:0] vector_in [N],
    output logic [DATA_WIDTH-1:0] vector_out [N],
    output logic [CW-1:0]         chainId_out,
    output logic                  valid_out,
    output logic                  eof_out,
    output logic                  bof_out,
    output logic                  sat_out
);

    localparam logic [7:0]  MY_ID          = 8'(PERSONAL_CONFIG_ID);
    localparam logic [31:0] MAX_CHAINS_U   = 32'(MAX_CHAINS);

    logic [DATA_WIDTH-1:0] acc_reg [MAX_CHAINS][N];
    logic [MAX_CHAINS-1:0] sat_sticky_reg;
    logic [7:0]            fw_acc_en_reg [MAX_CHAINS];
    logic [7:0]            byte_counter_reg;

    logic [DATA_WIDTH-1:0] sum_next [N];
    logic [N-1:0]          lane_sat;
    logic                  chain_in_range;
    logic                  acc_mode;
    logic                  prior_sat;
    logic                  any_sat;
    logic                  cfg_slot_valid;

    // Lane adders: one extra bit catches overflow; bof ignores the stale accumulator.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] base;
            logic [DATA_WIDTH:0]   wide;
            assign base          = bof_in ? '0 : acc_reg[chainId_in][gi];
            assign wide          = {1'b0, base} + {1'b0, vector_in[gi]};
            assign lane_sat[gi]  = wide[DATA_WIDTH];
            assign sum_next[gi]  = wide[DATA_WIDTH] ? '1 : wide[DATA_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        chain_in_range = ({{(32-CW){1'b0}}, chainId_in} < MAX_CHAINS_U);
        acc_mode       = 1'b0;
        prior_sat      = 1'b0;
        any_sat        = |lane_sat;
        cfg_slot_valid = ({24'd0, byte_counter_reg} < MAX_CHAINS_U);
        if (chain_in_range) begin
            acc_mode  = (fw_acc_en_reg[chainId_in] == 8'd1);
            prior_sat = !bof_in && sat_sticky_reg[chainId_in];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                vector_out[k] <= '0;
            end
            chainId_out      <= '0;
            valid_out        <= 1'b0;
            eof_out          <= 1'b0;
            bof_out          <= 1'b0;
            sat_out          <= 1'b0;
            sat_sticky_reg   <= '0;
            byte_counter_reg <= 8'd0;
            for (int c = 0; c < MAX_CHAINS; c++) begin
                fw_acc_en_reg[c] <= INITIAL_FIRMWARE_ACC_EN[8*c +: 8];
                for (int k = 0; k < N; k++) begin
                    acc_reg[c][k] <= '0;
                end
            end
        end else if (tracing) begin
            if (!valid_in) begin
                valid_out <= 1'b0;
            end else if (acc_mode) begin
                if (eof_in) begin
                    vector_out  <= sum_next;
                    valid_out   <= 1'b1;
                    bof_out     <= 1'b1;
                    eof_out     <= 1'b1;
                    chainId_out <= chainId_in;
                    sat_out     <= prior_sat | any_sat;
                    sat_sticky_reg[chainId_in] <= 1'b0;
                    for (int k = 0; k < N; k++) begin
                        acc_reg[chainId_in][k] <= '0;
                    end
                end else begin
                    valid_out                  <= 1'b0;
                    acc_reg[chainId_in]        <= sum_next;
                    sat_sticky_reg[chainId_in] <= prior_sat | any_sat;
                end
            end else begin
                vector_out  <= vector_in;
                valid_out   <= 1'b1;
                bof_out     <= bof_in;
                eof_out     <= eof_in;
                chainId_out <= chainId_in;
                sat_out     <= 1'b0;
            end
        end else begin
            // Configuration window: accumulators hold so a frame may resume afterwards.
            valid_out <= 1'b0;
            if (configId == MY_ID) begin
                if (cfg_slot_valid) begin
                    fw_acc_en_reg[byte_counter_reg[CW-1:0]] <= configData;
                end
                if (byte_counter_reg != 8'hFF) begin
                    byte_counter_reg <= byte_counter_reg + 8'd1;
                end
            end else begin
                byte_counter_reg <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_frame_vector_accumulator.sv
// Directed test-plan steps followed by random traffic, each cycle checked
// against a lane-arithmetic reference model of per-chain frame sums.
module tb_frame_vector_accumulator;

    logic       clk = 1'b0;
    logic       reset, tracing, valid_in, eof_in, bof_in;
    logic [1:0] chainId_in;
    logic [7:0] configId, configData;
    logic [7:0] vector_in [4];
    logic [7:0] vector_out [4];
    logic [1:0] chainId_out;
    logic       valid_out, eof_out, bof_out, sat_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int m_acc [4][4];
    bit m_sat [4];
    bit m_mode [4];
    int m_cnt;
    int e_vec [4];
    int e_ch;
    bit e_valid, e_bof, e_eof, e_sat;

    always #5 clk = ~clk;

    frame_vector_accumulator #(
        .N(4), .DATA_WIDTH(8), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(1),
        .INITIAL_FIRMWARE_ACC_EN(32'h0000_0001)
    ) dut (
        .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in),
        .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
        .configId(configId), .configData(configData), .vector_in(vector_in),
        .vector_out(vector_out), .chainId_out(chainId_out), .valid_out(valid_out),
        .eof_out(eof_out), .bof_out(bof_out), .sat_out(sat_out)
    );

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit tr, input bit v, input bit b, input bit e,
                              input int ch, input logic [31:0] vec, input int cid, input int cd);
        int tot;
        bit s;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                for (int k = 0; k < 4; k++) m_acc[c][k] = 0;
                m_sat[c]  = 0;
                m_mode[c] = (c == 0);
            end
            for (int k = 0; k < 4; k++) e_vec[k] = 0;
            m_cnt = 0; e_ch = 0; e_valid = 0; e_bof = 0; e_eof = 0; e_sat = 0;
        end else if (!tr) begin
            e_valid = 0;
            if (cid == 1) begin
                if (m_cnt < 4) m_mode[m_cnt] = (cd == 1);
                if (m_cnt < 255) m_cnt++;
            end else begin
                m_cnt = 0;
            end
        end else if (!v) begin
            e_valid = 0;
        end else if (m_mode[ch]) begin
            if (b) begin
                for (int k = 0; k < 4; k++) m_acc[ch][k] = 0;
                m_sat[ch] = 0;
            end
            s = m_sat[ch];
            for (int k = 0; k < 4; k++) begin
                tot = m_acc[ch][k] + int'(vec[8*k +: 8]);
                if (tot > 255) begin
                    tot = 255;
                    s = 1;
                end
                m_acc[ch][k] = tot;
            end
            if (e) begin
                for (int k = 0; k < 4; k++) begin
                    e_vec[k] = m_acc[ch][k];
                    m_acc[ch][k] = 0;
                end
                e_valid = 1; e_bof = 1; e_eof = 1; e_ch = ch; e_sat = s;
                m_sat[ch] = 0;
            end else begin
                e_valid = 0;
                m_sat[ch] = s;
            end
        end else begin
            for (int k = 0; k < 4; k++) e_vec[k] = int'(vec[8*k +: 8]);
            e_valid = 1; e_bof = b; e_eof = e; e_ch = ch; e_sat = 0;
        end
    endtask

    task automatic step(input bit rst, input bit tr, input bit v, input bit b, input bit e,
                        input int ch, input logic [31:0] vec, input int cid, input int cd);
        reset = rst; tracing = tr; valid_in = v; bof_in = b; eof_in = e;
        chainId_in = 2'(ch); configId = 8'(cid); configData = 8'(cd);
        for (int k = 0; k < 4; k++) vector_in[k] = vec[8*k +: 8];
        model_step(rst, tr, v, b, e, ch, vec, cid, cd);
        @(posedge clk);
        #1;
        chk("valid_out", 32'(valid_out), 32'(e_valid));
        chk("bof_out", 32'(bof_out), 32'(e_bof));
        chk("eof_out", 32'(eof_out), 32'(e_eof));
        chk("sat_out", 32'(sat_out), 32'(e_sat));
        chk("chainId_out", 32'(chainId_out), e_ch);
        for (int k = 0; k < 4; k++) chk($sformatf("vector_out[%0d]", k), 32'(vector_out[k]), e_vec[k]);
        $display("t=%0t rst=%0b tr=%0b v=%0b b=%0b e=%0b ch=%0d in=%h -> vo=%0b ch=%0d out=%0d,%0d,%0d,%0d sat=%0b",
                 $time, rst, tr, v, b, e, ch, vec, valid_out, chainId_out,
                 vector_out[0], vector_out[1], vector_out[2], vector_out[3], sat_out);
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic cfg(input int cid, input int cd);
        step(0, 0, 0, 0, 0, 0, 32'h0, cid, cd);
    endtask

    initial begin
        reset = 1; tracing = 0; valid_in = 0; bof_in = 0; eof_in = 0;
        chainId_in = 0; configId = 0; configData = 0;
        for (int k = 0; k < 4; k++) vector_in[k] = 0;

        step(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        step(1, 1, 1, 1, 1, 0, pk(9, 9, 9, 9), 0, 0);
        chk("reset_valid_zero", 32'(valid_out), 32'd0);

        // Three-vector frame on chain 0
        step(0, 1, 1, 1, 0, 0, pk(1, 2, 3, 4), 0, 0);
        step(0, 1, 1, 0, 0, 0, pk(1, 1, 1, 1), 0, 0);
        chk("frame_mid_valid", 32'(valid_out), 32'd0);
        step(0, 1, 1, 0, 1, 0, pk(0, 0, 0, 10), 0, 0);
        chk("frame_lane3", 32'(vector_out[3]), 32'd15);
        idle();

        // Saturation, then a clean single-vector frame
        step(0, 1, 1, 1, 0, 0, pk(200, 0, 0, 0), 0, 0);
        step(0, 1, 1, 0, 1, 0, pk(100, 1, 0, 0), 0, 0);
        chk("sat_lane0", 32'(vector_out[0]), 32'd255);
        chk("sat_flag", 32'(sat_out), 32'd1);
        step(0, 1, 1, 1, 1, 0, pk(5, 5, 5, 5), 0, 0);
        chk("single_sat_clear", 32'(sat_out), 32'd0);

        // Chains 0,1,3 accumulate; chain 2 passthrough
        cfg(1, 1); cfg(1, 1); cfg(1, 0); cfg(1, 1);
        step(0, 1, 1, 1, 0, 0, pk(1, 1, 1, 1), 0, 0);
        step(0, 1, 1, 1, 0, 1, pk(10, 10, 10, 10), 0, 0);
        step(0, 1, 1, 0, 1, 0, pk(1, 1, 1, 1), 0, 0);
        chk("ilv_c0_lane2", 32'(vector_out[2]), 32'd2);
        step(0, 1, 1, 0, 1, 1, pk(10, 10, 10, 10), 0, 0);
        chk("ilv_c1_lane1", 32'(vector_out[1]), 32'd20);
        chk("ilv_c1_chain", 32'(chainId_out), 32'd1);
        step(0, 1, 1, 1, 0, 2, pk(7, 8, 9, 10), 0, 0);
        chk("pass_lane3", 32'(vector_out[3]), 32'd10);
        chk("pass_eof", 32'(eof_out), 32'd0);

        // Write restart after a foreign configId
        cfg(1, 1); cfg(1, 0); cfg(0, 1);
        cfg(1, 1); cfg(1, 0); cfg(1, 1); cfg(1, 1); cfg(1, 0); cfg(1, 0);
        step(0, 1, 1, 1, 0, 1, pk(4, 4, 4, 4), 0, 0);
        chk("cfg_c1_pass", 32'(valid_out), 32'd1);
        step(0, 1, 1, 1, 0, 2, pk(1, 1, 1, 1), 0, 0);
        step(0, 1, 1, 0, 1, 2, pk(1, 2, 1, 1), 0, 0);
        chk("cfg_c2_acc", 32'(vector_out[1]), 32'd3);

        // Reset mid-frame loses partial sums and restores initial modes
        step(0, 1, 1, 1, 0, 0, pk(3, 3, 3, 3), 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        step(0, 1, 1, 0, 1, 0, pk(1, 1, 1, 1), 0, 0);
        chk("rst_frame_lane0", 32'(vector_out[0]), 32'd1);
        step(0, 1, 1, 1, 0, 2, pk(9, 9, 9, 9), 0, 0);
        chk("rst_c2_pass", 32'(valid_out), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(1, $urandom_range(0, 1), 1, 0, 0, 0, 32'h0, 1, 1);
            end else if (r < 14) begin
                cfg(($urandom_range(0, 3) == 0) ? 5 : 1, $urandom_range(0, 2));
            end else begin
                step(0, 1, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom(), 0, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
